// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM state encoding for the direct-mapped data cache.
package data_cache_pkg;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WB,
    MEM_FETCH,
    UPDATE
  } state_t;
endpackage

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache: hits complete with zero stall,
// misses hold BUSYWAIT high through optional write-back, block fetch and one fill cycle.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [7:0]          ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic [5:0]          MEM_ADDRESS,
  output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]  MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);

  logic               valid_q [NUM_LINES];
  logic               dirty_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_q   [NUM_LINES];
  logic [BLOCK_W-1:0] data_q  [NUM_LINES];

  state_t             state_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [5:0]         mem_addr_q;
  logic [BLOCK_W-1:0] mem_wdata_q;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-1:0]   off;
  logic               req;
  logic               hit;
  logic [BLOCK_W-1:0] hit_block_d;

  assign tag = ADDRESS[7:5];
  assign idx = ADDRESS[4:2];
  assign off = ADDRESS[1:0];
  assign req = READ | WRITE;
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // Indexed line with the store byte merged in; committed only on an IDLE write hit.
  always_comb begin
    hit_block_d = data_q[idx];
    hit_block_d[{off, 3'b000} +: 8] = WRITEDATA;
  end

  assign READDATA      = RESET ? 8'h00 : data_q[idx][{off, 3'b000} +: 8];
  assign BUSYWAIT      = !RESET && req && !(state_q == IDLE && hit);
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (WRITE) begin
                data_q[idx]  <= hit_block_d;
                dirty_q[idx] <= 1'b1;
              end
            end else if (dirty_q[idx]) begin
              state_q     <= MEM_WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx};
              mem_wdata_q <= data_q[idx];
            end else begin
              state_q    <= MEM_FETCH;
              mem_read_q <= 1'b1;
              mem_addr_q <= ADDRESS[7:2];
            end
          end
        end
        MEM_WB: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= MEM_FETCH;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= ADDRESS[7:2];
          end
        end
        MEM_FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_q    <= UPDATE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        UPDATE: begin
          // Memory keeps the fetched block on MEM_READDATA through this cycle.
          data_q[idx]  <= MEM_READDATA;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          tag_q[idx]   <= tag;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: transaction-level cache/memory model, per-cycle compare process,
// fixed-latency block memory, directed access sequence with literal pins.
module tb_data_cache;
  localparam int LAT = 2;

  logic        CLK, RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Block memory, and the byte-level memory image the CPU should observe.
  logic [31:0] mem [64];
  logic [7:0]  golden [256];
  // Cache directory model: which block each line holds and whether it is modified.
  logic        mvalid [8];
  logic        mdirty [8];
  logic [2:0]  mtag   [8];

  // Expectations for the access in flight.
  logic        req_active = 1'b0;
  logic        chk_en = 1'b0;
  int          req_cyc = 0;
  int          e_stall, e_f0;
  logic        e_miss, e_wb, e_rd_only;
  logic [5:0]  e_wb_addr, e_f_addr;
  logic [31:0] e_wb_data;
  logic [7:0]  e_addr;
  logic [7:0]  last_rd;
  logic [31:0] wb_seen;

  // Memory: holds MEM_BUSYWAIT high LAT cycles per request, then completes for one cycle.
  int mcount;
  initial begin
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    mcount = 0;
    forever begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) begin
        if (mcount < LAT) begin
          MEM_BUSYWAIT = 1'b1;
          mcount++;
        end else begin
          MEM_BUSYWAIT = 1'b0;
          mcount = 0;
          if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
          else           MEM_READDATA = mem[MEM_ADDRESS];
        end
      end else begin
        MEM_BUSYWAIT = 1'b0;
        mcount = 0;
      end
    end
  end

  // Per-cycle compare against the access-level expectations.
  initial begin
    logic exp_busy, exp_mw, exp_mr;
    forever begin
      @(negedge CLK);
      #2;
      if (chk_en) begin
        if (req_active) begin
          exp_busy = (req_cyc < e_stall);
          exp_mw   = e_wb && req_cyc >= 1 && req_cyc <= LAT + 1;
          exp_mr   = e_miss && req_cyc >= e_f0 && req_cyc <= e_f0 + LAT;
          chk("busywait", {31'd0, BUSYWAIT}, {31'd0, exp_busy});
          chk("mem_write", {31'd0, MEM_WRITE}, {31'd0, exp_mw});
          chk("mem_read", {31'd0, MEM_READ}, {31'd0, exp_mr});
          if (exp_mw) begin
            chk("wb_addr", {26'd0, MEM_ADDRESS}, {26'd0, e_wb_addr});
            chk("wb_data", MEM_WRITEDATA, e_wb_data);
            wb_seen = MEM_WRITEDATA;
          end
          if (exp_mr) chk("fetch_addr", {26'd0, MEM_ADDRESS}, {26'd0, e_f_addr});
          if (!exp_busy && e_rd_only) begin
            chk("readdata", {24'd0, READDATA}, {24'd0, golden[e_addr]});
            last_rd = READDATA;
          end
          req_cyc++;
        end else begin
          chk("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);
          chk("idle_mem_read", {31'd0, MEM_READ}, 32'd0);
          chk("idle_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd);
    logic [2:0] idx, tg;
    @(negedge CLK);
    idx = addr[4:2];
    tg  = addr[7:5];
    e_miss    = !(mvalid[idx] && mtag[idx] == tg);
    e_wb      = e_miss && mdirty[idx];
    e_wb_addr = {mtag[idx], idx};
    for (int j = 0; j < 4; j++) e_wb_data[8*j +: 8] = golden[{mtag[idx], idx, 2'(j)}];
    e_f0      = e_wb ? LAT + 2 : 1;
    e_stall   = !e_miss ? 0 : (e_wb ? 2 * LAT + 4 : LAT + 3);
    e_rd_only = rd && !wr;
    e_addr    = addr;
    e_f_addr  = addr[7:2];
    last_rd   = 8'h00;
    wb_seen   = 32'h0;
    req_cyc   = 0;
    req_active = 1'b1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    repeat (e_stall + 1) @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    req_active = 1'b0;
    if (e_miss) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      golden[addr] = wd;
      mdirty[idx]  = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    for (int a = 0; a < 256; a++) golden[a] = mem[a >> 2][8 * (a % 4) +: 8];
  endtask

  initial begin
    logic seen;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    for (int b = 0; b < 64; b++)
      for (int j = 0; j < 4; j++) mem[b][8*j +: 8] = 8'(4 * b + j) ^ 8'h5A;
    model_reset();

    @(negedge CLK);
    #2;
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("rst_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
    chk("rst_readdata", {24'd0, READDATA}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    chk_en = 1'b1;

    access(1, 0, 8'h01, 8'h00); chk("lit_miss_rd01", {24'd0, last_rd}, 32'h5B);
    access(1, 0, 8'h01, 8'h00); chk("lit_hit_rd01", {24'd0, last_rd}, 32'h5B);
    access(1, 0, 8'h03, 8'h00); chk("lit_hit_rd03", {24'd0, last_rd}, 32'h59);
    access(0, 1, 8'h00, 8'h0A);
    access(1, 0, 8'h00, 8'h00); chk("lit_rd00_after_wr", {24'd0, last_rd}, 32'h0A);
    access(0, 1, 8'h20, 8'h16); chk("lit_wb_block", wb_seen, 32'h59585B0A);
    chk("lit_mem0_written_back", mem[0], 32'h59585B0A);
    access(1, 0, 8'h20, 8'h00); chk("lit_rd20", {24'd0, last_rd}, 32'h16);
    access(1, 0, 8'h19, 8'h00); chk("lit_clean_rd19", {24'd0, last_rd}, 32'h43);
    access(1, 1, 8'h19, 8'h77);
    access(1, 0, 8'h19, 8'h00); chk("lit_rdwr_as_write", {24'd0, last_rd}, 32'h77);

    // Abandon a clean-miss fetch with reset.
    chk_en = 1'b0;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h44;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      #2;
      seen = MEM_READ;
    end
    chk("midfetch_mem_read_seen", {31'd0, seen}, 32'd1);
    chk("midfetch_addr", {26'd0, MEM_ADDRESS}, 32'h11);
    RESET = 1'b1;
    @(negedge CLK);
    #2;
    chk("midfetch_rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("midfetch_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0; READ = 1'b0;
    model_reset();
    chk_en = 1'b1;

    access(1, 0, 8'h01, 8'h00); chk("lit_post_rst_rd01", {24'd0, last_rd}, 32'h5B);
    access(1, 0, 8'h00, 8'h00); chk("lit_post_rst_rd00", {24'd0, last_rd}, 32'h0A);
    access(1, 0, 8'h20, 8'h00); chk("lit_post_rst_rd20", {24'd0, last_rd}, 32'h7A);
    access(1, 0, 8'h19, 8'h00); chk("lit_post_rst_rd19", {24'd0, last_rd}, 32'h43);
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
